// File: rtl/pa_spsram_ctrl_4096x32_pkg.sv
// Shared constants, pin bundle and byte-lane helper for the 4096x32 SRAM request controller.
package pa_spsram_ctrl_4096x32_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int DEPTH      = 4096;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic                  cen;
    logic                  gwen;
    logic [DATA_WIDTH-1:0] wen;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
  } sram_pins_t;

  localparam sram_pins_t SRAM_IDLE = '{cen: 1'b1, gwen: 1'b1, wen: '1, a: '0, d: '0};

  // Low-active bit write enables: a lane is written only on a write with its strobe set.
  function automatic logic [DATA_WIDTH-1:0] be_to_wen(input logic wr,
                                                      input logic [BE_WIDTH-1:0] be);
    logic [DATA_WIDTH-1:0] wen;
    wen = '1;
    for (int i = 0; i < BE_WIDTH; i++) begin
      wen[8*i +: 8] = {8{~(wr & be[i])}};
    end
    return wen;
  endfunction

endpackage

// File: rtl/pa_spsram_ctrl_4096x32_if.sv
// Request/response handshake plus SRAM macro pins. Handshakes: a transfer happens at the
// rising edge where valid and ready are both 1; valid never depends on ready of the same channel.
interface pa_spsram_ctrl_4096x32_if;
  import pa_spsram_ctrl_4096x32_pkg::*;

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;
  logic [0:0]            dbg_state;

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy, sram_q,
    output req_rdy, rsp_vld, rsp_rdata, init_done,
    output sram_cen, sram_gwen, sram_wen, sram_a, sram_d, dbg_state
  );

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_be, rsp_rdy, sram_q,
    input  req_rdy, rsp_vld, rsp_rdata, init_done,
    input  sram_cen, sram_gwen, sram_wen, sram_a, sram_d, dbg_state
  );

endinterface

// File: rtl/pa_spsram_ctrl_4096x32_rsp_fifo.sv
// Two-entry in-order read-data buffer; push and pop may coincide at any occupancy.
module pa_spsram_ctrl_rsp_fifo
  import pa_spsram_ctrl_4096x32_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [FIFO_CNT_W-1:0] cnt_q;
  logic [FIFO_CNT_W-1:0] cnt_d;

  assign cnt_d = cnt_q + FIFO_CNT_W'(push_i) - FIFO_CNT_W'(pop_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/pa_spsram_ctrl_4096x32.sv
// Request-side controller for the 4096x32 single-port SRAM macro.
// Define PA_SPSRAM_CTRL_INIT_EN to zero-fill the whole array after reset.
module pa_spsram_ctrl_4096x32
  import pa_spsram_ctrl_4096x32_pkg::*;
(
  input logic                     forever_cpuclk,
  input logic                     cpurst,
  pa_spsram_ctrl_4096x32_if.slave bus
);

  logic [0:0]            state_q;
  logic                  init_active;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef PA_SPSRAM_CTRL_INIT_EN
  logic [0:0]            state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic [ADDR_WIDTH-1:0] init_cnt_d;

  // The counter parks on the last word when the sweep hands over to RUN.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_active = (state_q == ST_INIT) && !cpurst;
  assign init_addr   = init_cnt_q;
`else
  assign state_q     = ST_RUN;
  assign init_active = 1'b0;
  assign init_addr   = '0;
`endif

  logic                  rd_inflight_q;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  pop;
  logic                  req_rdy;
  logic                  accept;
  logic [2:0]            credits_used;
  sram_pins_t            pins;

  // A pop in the same cycle frees its slot, keeping one read per cycle under rsp_rdy=1.
  assign pop          = (fifo_cnt != '0) && bus.rsp_rdy;
  assign credits_used = 3'(fifo_cnt) + 3'(rd_inflight_q) - 3'(pop);
  assign req_rdy      = (state_q == ST_RUN) && !cpurst && (credits_used < 3'd2);
  assign accept       = bus.req_vld && req_rdy;

  always_comb begin
    pins = SRAM_IDLE;
    if (init_active) begin
      pins.cen  = 1'b0;
      pins.gwen = 1'b0;
      pins.wen  = '0;
      pins.a    = init_addr;
      pins.d    = '0;
    end else if (accept) begin
      pins.cen  = 1'b0;
      pins.gwen = ~bus.req_wr;
      pins.wen  = be_to_wen(bus.req_wr, bus.req_be);
      pins.a    = bus.req_addr;
      pins.d    = bus.req_wdata;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) rd_inflight_q <= 1'b0;
    else        rd_inflight_q <= accept && !bus.req_wr;
  end

  pa_spsram_ctrl_rsp_fifo u_rsp_fifo (
    .clk_i       (forever_cpuclk),
    .rst_i       (cpurst),
    .push_i      (rd_inflight_q),
    .push_data_i (bus.sram_q),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .count_o     (fifo_cnt)
  );

  assign bus.req_rdy   = req_rdy;
  assign bus.rsp_vld   = (fifo_cnt != '0);
  assign bus.rsp_rdata = fifo_data;
  assign bus.init_done = (state_q == ST_RUN);
  assign bus.dbg_state = state_q;
  assign bus.sram_cen  = pins.cen;
  assign bus.sram_gwen = pins.gwen;
  assign bus.sram_wen  = pins.wen;
  assign bus.sram_a    = pins.a;
  assign bus.sram_d    = pins.d;

endmodule

// File: tb/tb_pa_spsram_ctrl_4096x32.sv
// Bench for pa_spsram_ctrl_4096x32: SRAM macro model, behavioural reference, directed and random traffic.
module tb_pa_spsram_ctrl_4096x32;
  import pa_spsram_ctrl_4096x32_pkg::*;

`ifdef PA_SPSRAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pa_spsram_ctrl_4096x32_if bus ();

  pa_spsram_ctrl_4096x32 dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SRAM macro model ----------------
  logic [31:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.sram_cen === 1'b0) begin
      if (bus.sram_gwen === 1'b0)
        sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
      else
        bus.sram_q <= sram_mem[bus.sram_a];
    end
  end

  int rsp_mode = 1;  // 0: hold rsp_rdy low, 1: hold high, 2: random
  always @(posedge clk) begin
    #2;
    bus.rsp_rdy = (rsp_mode == 2) ? 1'($urandom_range(0, 1)) : (rsp_mode == 1);
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  bit          pend_vld = 1'b0;
  logic [31:0] pend_data;
  int          init_left = 0;
  bit          m_rdy, m_acc, m_pop;
  logic        e_cen, e_gwen;
  logic [31:0] e_wen, e_d;
  logic [11:0] e_a;

  always @(negedge clk) begin
    e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1; e_a = '0; e_d = '0;
    m_rdy = 1'b0; m_acc = 1'b0;
    m_pop = !rst && (exp_q.size() > 0) && (bus.rsp_rdy === 1'b1);
    if (!rst && init_left > 0) begin
      e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0; e_a = 12'(DEPTH - init_left);
    end else if (!rst) begin
      m_rdy = (exp_q.size() + int'(pend_vld) - int'(m_pop)) < 2;
      m_acc = (bus.req_vld === 1'b1) && m_rdy;
      if (m_acc) begin
        e_cen = 1'b0; e_gwen = !bus.req_wr; e_a = bus.req_addr; e_d = bus.req_wdata;
        for (int i = 0; i < 4; i++)
          e_wen[8*i +: 8] = (bus.req_wr && bus.req_be[i]) ? 8'h00 : 8'hFF;
      end
    end
    chk("req_rdy", 64'(bus.req_rdy), 64'(m_rdy));
    chk("sram_cen", 64'(bus.sram_cen), 64'(e_cen));
    chk("sram_gwen", 64'(bus.sram_gwen), 64'(e_gwen));
    chk("sram_wen", 64'(bus.sram_wen), 64'(e_wen));
    chk("sram_a", 64'(bus.sram_a), 64'(e_a));
    chk("sram_d", 64'(bus.sram_d), 64'(e_d));
    if (!rst) begin
      chk("init_done", 64'(bus.init_done), 64'(init_left == 0));
      chk("rsp_vld", 64'(bus.rsp_vld), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_q[0]));
    end
    // advance the model to the state after the coming rising edge
    if (rst) begin
      exp_q.delete();
      pend_vld  = 1'b0;
      init_left = INIT_EN ? DEPTH : 0;
      if (INIT_EN) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      if (init_left > 0) init_left--;
      if (m_pop) void'(exp_q.pop_front());
      if (pend_vld) exp_q.push_back(pend_data);
      pend_vld = 1'b0;
      if (m_acc) begin
        if (bus.req_wr) begin
          for (int i = 0; i < 4; i++)
            if (bus.req_be[i]) ref_mem[bus.req_addr][8*i +: 8] = bus.req_wdata[8*i +: 8];
        end else begin
          pend_vld  = 1'b1;
          pend_data = ref_mem[bus.req_addr];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] be, output int waits, output int acc_cyc);
    bit acc = 1'b0;
    waits = 0;
    bus.req_vld = 1'b1; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = d; bus.req_be = be;
    while (!acc && waits < 500) begin
      @(negedge clk);
      acc = (bus.req_rdy === 1'b1);
      @(posedge clk); #1;
      waits++;
    end
    bus.req_vld = 1'b0;
    acc_cyc = cyc;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: addr %0h not accepted within 500 cycles", a);
    end
  endtask

  task automatic get_rsp(output logic [31:0] d, output int c);
    d = '0; c = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (bus.rsp_vld === 1'b1 && bus.rsp_rdy === 1'b1) begin
        d = bus.rsp_rdata; c = cyc;
        @(posedge clk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL rsp_timeout: no response within 500 cycles");
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.init_done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n), INIT_EN ? 64'(DEPTH) : 64'd0);
    chk({name, "_rdy"}, 64'(bus.req_rdy), 64'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  int w, ac, c;
  logic [31:0] d;
  int bp_acc;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      sram_mem[i] <= v;
      ref_mem[i] = v;
    end
    bus.sram_q <= '0;
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("first_req_rdy", 64'(bus.req_rdy), INIT_EN ? 64'd0 : 64'd1);
    chk("first_init_done", 64'(bus.init_done), INIT_EN ? 64'd0 : 64'd1);
    @(posedge clk); #1;
    wait_init("init_cycles");

    // fresh array reads zero (without the sweep, the word is zeroed first)
    if (!INIT_EN) send(1'b1, 12'hABC, 32'h0, 4'hF, w, ac);
    send(1'b0, 12'hABC, 32'h0, 4'h0, w, ac);
    get_rsp(d, c);
    chk("abc_zero", 64'(d), 64'h0);

    // partial byte write then read, with latency
    send(1'b1, 12'h010, 32'h0, 4'hF, w, ac);
    send(1'b1, 12'h010, 32'hDEADBEEF, 4'b0101, w, ac);
    send(1'b0, 12'h010, 32'h0, 4'h0, w, ac);
    get_rsp(d, c);
    chk("be_merge", 64'(d), 64'h00AD00EF);
    chk("rd_latency", 64'(c + 1 - ac), 64'd2);

    // backpressure: only two reads accepted while rsp_rdy is low
    for (int k = 1; k <= 4; k++) send(1'b1, 12'(k), 32'h11111111 * k, 4'hF, w, ac);
    rsp_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    bp_acc = 0;
    for (int k = 0; k < 6; k++) begin
      bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 12'(1 + bp_acc); bus.req_be = '0;
      @(negedge clk);
      if (bus.req_rdy === 1'b1) bp_acc++;
      @(posedge clk); #1;
    end
    bus.req_vld = 1'b0;
    chk("bp_accepts", 64'(bp_acc), 64'd2);
    rsp_mode = 1;
    fork
      begin
        int w2, a2;
        send(1'b0, 12'h003, 32'h0, 4'h0, w2, a2);
        send(1'b0, 12'h004, 32'h0, 4'h0, w2, a2);
      end
      begin
        logic [31:0] d2;
        int c2;
        for (int k = 1; k <= 4; k++) begin
          get_rsp(d2, c2);
          chk("bp_order", 64'(d2), 64'(32'h11111111 * k));
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // streaming reads with rsp_rdy held high: accepted on first try every cycle
    for (int k = 0; k < 8; k++) begin
      send(1'b0, 12'(k), 32'h0, 4'h0, w, ac);
      chk("stream_first_try", 64'(w), 64'd1);
    end
    repeat (4) @(posedge clk);
    #1;

    // reset right after a read is accepted
    send(1'b0, 12'h002, 32'h0, 4'h0, w, ac);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rsp_vld", 64'(bus.rsp_vld), 64'd0);
    chk("rst_mid_cen", 64'(bus.sram_cen), INIT_EN ? 64'd0 : 64'd1);
    chk("rst_mid_a", 64'(bus.sram_a), 64'd0);
    @(posedge clk); #1;
    wait_init("reinit_cycles");

    // top word write then read
    send(1'b1, 12'hFFF, 32'hCAFEF00D, 4'hF, w, ac);
    send(1'b0, 12'hFFF, 32'h0, 4'h0, w, ac);
    get_rsp(d, c);
    chk("fff_rd", 64'(d), 64'hCAFEF00D);

    // random traffic on a small address window to exercise read-after-write
    rsp_mode = 2;
    for (int k = 0; k < 400; k++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), w, ac);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rsp_mode = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drained_vld", 64'(bus.rsp_vld), 64'd0);
    chk("drained_q", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
